im_loader: RTL



---
 rtl/im_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Boot-time instruction memory loader: packs a byte stream into little-endian words and writes them to IM.
// Optional trailing checksum verification is enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] load_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        im_we,
  output logic [11:2] im_addr,
  output logic [31:0] im_din,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_FIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} state_t;
`endif

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [9:0]  word_cnt;
  logic [9:0]  last_idx;
  logic [23:0] byte_buf;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  logic        accept;
  logic [31:0] word_full;

  // byte_ready is only ever high in LOAD/CHECK, so accept is implicitly state-qualified
  assign accept    = byte_valid && byte_ready;
  assign word_full = {byte_in, byte_buf};

  // NOTE: every register here is assigned with <= so all of them update together on the edge;
  // a blocking = would let later statements see the new value and break the pipeline timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      last_idx   <= '0;
      byte_buf   <= '0;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_din     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    byte_buf[7:0]   <= byte_in;
          2'd1:    byte_buf[15:8]  <= byte_in;
          2'd2:    byte_buf[23:16] <= byte_in;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (load_words == 11'd0) begin
              err   <= 1'b0;
              busy  <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end else if (load_words > DEPTH_W) begin
              err <= 1'b1;
            end else begin
              err        <= 1'b0;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              byte_cnt   <= '0;
              word_cnt   <= '0;
              last_idx   <= 10'(load_words - 11'd1);
`ifdef IM_LOADER_CHECKSUM_EN
              sum        <= '0;
`endif
              state      <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (accept && byte_cnt == 2'd3) begin
            im_we    <= 1'b1;
            im_addr  <= word_cnt;
            im_din   <= word_full;
            word_cnt <= word_cnt + 10'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            sum      <= sum + word_full;
            if (word_cnt == last_idx) state <= S_CHECK;
`else
            if (word_cnt == last_idx) begin
              byte_ready <= 1'b0;
              done       <= ~err;
              state      <= S_FIN;
            end
`endif
          end
        end

`ifdef IM_LOADER_CHECKSUM_EN
        // Trailer bytes reuse the word assembler but never reach the memory port
        S_CHECK: begin
          if (accept && byte_cnt == 2'd3) begin
            byte_ready <= 1'b0;
            state      <= S_FIN;
            if (word_full == sum) done <= 1'b1;
            else                  err  <= 1'b1;
          end
        end
`endif

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
